scan_controller: RTL and testbench

SCAN_CONTROLLER -- requirements
Module: scan_controller

---
 rtl/scan_controller_pkg.sv | 25 ++
 rtl/scan_controller_scan_timer.sv | 23 ++
 rtl/scan_controller.sv | 126 ++++++++++++
 tb/tb_scan_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_controller_pkg.sv
// Shared definitions for the LED panel scan controller and the line renderer.
package scan_controller_pkg;

  localparam int NUM_ROWS_DEF  = 32;
  localparam int PWM_STEPS_DEF = 16;
  localparam int ROW_W         = 5;
  localparam int PWM_W         = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BEGIN   = 3'd1,
    GUARD   = 3'd2,
    SHIFT   = 3'd3,
    LATCH   = 3'd4,
    DISPLAY = 3'd5,
    ADVANCE = 3'd6
  } scan_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scan_controller_scan_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk_25MHz,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/scan_controller.sv
// Row/bit-plane scan sequencer: kicks the line renderer, then latches and
// displays each subframe on the panel.
module scan_controller
  import scan_controller_pkg::*;
#(
  parameter int NUM_ROWS       = NUM_ROWS_DEF,
  parameter int PWM_STEPS      = PWM_STEPS_DEF,
  parameter int DISPLAY_CYCLES = 64,
  parameter int LATCH_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_25MHz,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             line_done,
  output logic             line_begin,
  output logic [ROW_W-1:0] row_addr,
  output logic [PWM_W-1:0] pwm,
  output logic [ROW_W-1:0] panel_addr,
  output logic             lat,
  output logic             oe_n,
  output logic             frame_start,
  output logic             timeout_err
);

  localparam int CNT_MAX = max3(TIMEOUT_CYCLES, DISPLAY_CYCLES, LATCH_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISPLAY_CYCLES - 1);

  scan_state_t      state, state_nxt;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             to_set, adv;

  scan_timer #(.W(CNT_W)) u_timer (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .dec       (tmr_dec),
    .zero      (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    to_set    = 1'b0;
    adv       = 1'b0;
    unique case (state)
      IDLE:    if (enable) state_nxt = BEGIN;
      BEGIN:   state_nxt = GUARD;
      GUARD: begin
        state_nxt = SHIFT;
        tmr_load  = 1'b1;
        tmr_val   = TO_LOAD;
      end
      SHIFT: begin
        // A done arriving on the last permitted cycle still wins over timeout.
        if (line_done) begin
          state_nxt = LATCH;
          tmr_load  = 1'b1;
          tmr_val   = LAT_LOAD;
        end else if (tmr_zero) begin
          state_nxt = ADVANCE;
          to_set    = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      LATCH: begin
        if (tmr_zero) begin
          state_nxt = DISPLAY;
          tmr_load  = 1'b1;
          tmr_val   = DISP_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DISPLAY: begin
        if (tmr_zero) state_nxt = ADVANCE;
        else          tmr_dec   = 1'b1;
      end
      ADVANCE: begin
        adv       = 1'b1;
        state_nxt = enable ? BEGIN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_addr    <= '0;
      pwm         <= '0;
      panel_addr  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (to_set) timeout_err <= 1'b1;
      // Panel sees the new row from the first latch cycle onward.
      if (state == SHIFT && line_done) panel_addr <= row_addr;
      if (adv) begin
        if (pwm == PWM_W'(PWM_STEPS - 1)) begin
          pwm      <= '0;
          row_addr <= (row_addr == ROW_W'(NUM_ROWS - 1)) ? '0 : row_addr + 1'b1;
        end else begin
          pwm <= pwm + 1'b1;
        end
      end
    end
  end

  // Decoded straight from state so async reset releases the panel at once.
  assign line_begin  = (state == BEGIN);
  assign lat         = (state == LATCH);
  assign oe_n        = (state != DISPLAY);
  assign frame_start = (state == BEGIN) && (row_addr == '0) && (pwm == '0);

endmodule

// File: tb/tb_scan_controller.sv
// Self-checking bench for scan_controller with a behavioural line-renderer model.
module tb_scan_controller;

  localparam int NR = 32;
  localparam int NP = 16;

  logic       clk_25MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       enable    = 1'b0;
  logic       line_done = 1'b0;
  logic       line_begin, lat, oe_n, frame_start, timeout_err;
  logic [4:0] row_addr, panel_addr;
  logic [3:0] pwm;

  int tests = 0;
  int fails = 0;
  int idx   = 0;          // subframes completed since reset (model)
  int render_delay = 192; // 0 = renderer never finishes

  scan_controller dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .line_done   (line_done),
    .line_begin  (line_begin),
    .row_addr    (row_addr),
    .pwm         (pwm),
    .panel_addr  (panel_addr),
    .lat         (lat),
    .oe_n        (oe_n),
    .frame_start (frame_start),
    .timeout_err (timeout_err)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct {
    int delay; int len; int lat; int oe; int lat_off; int err;
  } vec_t;

  typedef struct {
    int len; int lat; int oe; int lat_off; int pa_ok; int got;
  } meas_t;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Renderer: done rises render_delay cycles after begin and stays high;
  // a previous done lingers through the begin and guard cycles.
  initial begin
    int since = 0;
    bit got_done = 0, stale = 0;
    forever begin
      @(negedge clk_25MHz);
      if (!rst_n) begin
        since = 0; got_done = 0; stale = 0; line_done = 1'b0;
      end else begin
        if (line_begin) begin
          since = 0; stale = got_done; got_done = 0;
        end else begin
          since++;
        end
        line_done = ((since <= 1) && stale) ||
                    (render_delay != 0 && since >= render_delay);
        if (since >= 2 && line_done) got_done = 1;
      end
    end
  end

  always @(negedge clk_25MHz)
    if (rst_n && lat && !oe_n) begin
      fails++;
      $display("FAIL lat_oe_overlap: lat=%0b oe_n=%0b", lat, oe_n);
    end

  task automatic wait_begin(input string nm, input int lim);
    bit seen = 0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk_25MHz);
      if (line_begin) begin seen = 1; break; end
    end
    chk(nm, int'(seen), 1);
  endtask

  // Called at the negedge of a begin cycle; checks it against the model.
  task automatic check_begin(input string nm);
    chk({nm, "_row"}, int'(row_addr), (idx / NP) % NR);
    chk({nm, "_pwm"}, int'(pwm), idx % NP);
    chk({nm, "_fs"},  int'(frame_start), (idx % (NR * NP)) == 0 ? 1 : 0);
  endtask

  // From a begin negedge, observe until the next begin or lim cycles.
  task automatic measure(input int drop_at, input int lim, input int exp_row,
                         output meas_t m);
    m = '{len: 0, lat: 0, oe: 0, lat_off: -1, pa_ok: 1, got: 0};
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk_25MHz);
      if (line_begin) begin m.len = c; m.got = 1; break; end
      if (lat) begin
        m.lat++;
        if (m.lat_off < 0) m.lat_off = c;
      end
      if (!oe_n) begin
        m.oe++;
        if (int'(panel_addr) != exp_row) m.pa_ok = 0;
        if (drop_at > 0 && m.oe == drop_at) enable = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t  tbl [7];
    meas_t m;
    int    fs_cnt, nb, d;

    tbl[0] = '{192, 260, 2, 64, 193, 0};
    tbl[1] = '{2,   70,  2, 64, 3,   0};
    tbl[2] = '{5,   73,  2, 64, 6,   0};
    tbl[3] = '{255, 323, 2, 64, 256, 0};
    tbl[4] = '{0,   258, 0, 0,  -1,  1};
    tbl[5] = '{257, 258, 0, 0,  -1,  1};
    tbl[6] = '{3,   71,  2, 64, 4,   1};

    // Reset values
    repeat (3) @(negedge clk_25MHz);
    chk("rst_row", int'(row_addr), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_panel", int'(panel_addr), 0);
    chk("rst_begin", int'(line_begin), 0);
    chk("rst_lat", int'(lat), 0);
    chk("rst_oe_n", int'(oe_n), 1);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_err", int'(timeout_err), 0);

    // Idle with enable low
    rst_n = 1'b1;
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_25MHz);
      if (line_begin || !oe_n) nb++;
    end
    chk("idle_quiet", nb, 0);

    enable = 1'b1;
    wait_begin("first_begin", 4);

    // Table of single subframes with different renderer latencies
    for (int i = 0; i < 7; i++) begin
      render_delay = tbl[i].delay;
      check_begin($sformatf("v%0d", i));
      measure(0, 600, (idx / NP) % NR, m);
      chk($sformatf("v%0d_got", i), m.got, 1);
      chk($sformatf("v%0d_len", i), m.len, tbl[i].len);
      chk($sformatf("v%0d_lat", i), m.lat, tbl[i].lat);
      chk($sformatf("v%0d_oe", i), m.oe, tbl[i].oe);
      chk($sformatf("v%0d_latoff", i), m.lat_off, tbl[i].lat_off);
      chk($sformatf("v%0d_panel", i), m.pa_ok, 1);
      chk($sformatf("v%0d_err", i), int'(timeout_err), tbl[i].err);
      idx++;
    end

    // Drop enable mid-display: subframe completes, then idles
    render_delay = 10;
    check_begin("drop");
    measure(20, 300, (idx / NP) % NR, m);
    chk("drop_nobegin", m.got, 0);
    chk("drop_lat", m.lat, 2);
    chk("drop_oe", m.oe, 64);
    chk("drop_idle_oe_n", int'(oe_n), 1);
    idx++;
    enable = 1'b1;
    wait_begin("resume_begin", 3);
    check_begin("resume");

    // Reset mid-shift
    render_delay = 192;
    repeat (10) @(negedge clk_25MHz);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_shift_oe_n", int'(oe_n), 1);
    chk("rst_shift_err", int'(timeout_err), 0);
    chk("rst_shift_row", int'(row_addr), 0);
    chk("rst_shift_pwm", int'(pwm), 0);
    @(negedge clk_25MHz);
    rst_n = 1'b1;
    idx = 0;
    wait_begin("restart_begin", 4);
    check_begin("restart");

    // Reset mid-display must release oe_n immediately
    render_delay = 5;
    nb = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_25MHz);
      if (!oe_n) begin nb = 1; break; end
    end
    chk("disp_reached", nb, 1);
    repeat (5) @(negedge clk_25MHz);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_disp_oe_n", int'(oe_n), 1);
    chk("rst_disp_lat", int'(lat), 0);
    @(negedge clk_25MHz);
    rst_n = 1'b1;
    idx = 0;
    wait_begin("rerun_begin", 4);

    // Random renderer latency over a full frame plus one
    fs_cnt = 0;
    for (int i = 0; i < NR * NP; i++) begin
      d = int'($urandom_range(40, 2));
      render_delay = d;
      if (frame_start) fs_cnt++;
      check_begin("rnd");
      measure(0, 200, (idx / NP) % NR, m);
      chk("rnd_len", m.len, 2 + (d - 1) + 2 + 64 + 1);
      chk("rnd_lat", m.lat, 2);
      chk("rnd_oe", m.oe, 64);
      chk("rnd_panel", m.pa_ok, 1);
      idx++;
    end
    if (frame_start) fs_cnt++;
    check_begin("wrap");
    chk("frame_start_count", fs_cnt, 2);
    chk("rnd_err", int'(timeout_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
